mc_ctrl_fsm: RTL and testbench

Registered multi-cycle control sequencer for the CPU datapath. It combines the state register with next-state logic and adds three things:
- memory ready handshakes on the fetch and memory stages,
- a resumable HALT state and a sticky timeout FAULT state,
- retire, cycle and instruction counters.

It drives the datapath control decoder through `state`, and replaces the purely combinational next-state block.

---
 rtl/mc_ctrl_fsm_pkg.sv | 39 +++
 rtl/mc_ctrl_fsm_if.sv | 33 +++
 rtl/mc_ctrl_fsm_op_class_decode.sv | 23 ++
 rtl/mc_ctrl_fsm.sv | 124 ++++++++++++
 tb/tb_mc_ctrl_fsm.sv | 190 +++++++++++++++++++
 5 files changed

// File: rtl/mc_ctrl_fsm_pkg.sv
// mc_ctrl_pkg: shared definitions for the multi-cycle control sequencer and
// the datapath control decoder.
//   - state encodings (state_t) and STATE_W
//   - opcode constants recognised by the sequencer
//   - instruction class encoding (op_cls_t) produced by op_class_decode
package mc_ctrl_pkg;

  localparam int STATE_W = 4;

  typedef enum logic [STATE_W-1:0] {
    S_IF      = 4'b0000,
    S_ID      = 4'b0001,
    S_EXE_MEM = 4'b0010,
    S_MEM     = 4'b0011,
    S_WB_LD   = 4'b0100,
    S_EXE_BR  = 4'b0101,
    S_EXE_ALU = 4'b0110,
    S_WB_ALU  = 4'b0111,
    S_HALT    = 4'b1000,
    S_FAULT   = 4'b1001
  } state_t;

  localparam logic [5:0] OP_J    = 6'b111000;
  localparam logic [5:0] OP_JAL  = 6'b111010;
  localparam logic [5:0] OP_JR   = 6'b111001;
  localparam logic [5:0] OP_HALT = 6'b111111;
  localparam logic [5:0] OP_BEQ  = 6'b110100;
  localparam logic [5:0] OP_SW   = 6'b110000;
  localparam logic [5:0] OP_LW   = 6'b110001;

  typedef enum logic [2:0] {
    CLS_JUMP = 3'd0,
    CLS_HALT = 3'd1,
    CLS_BR   = 3'd2,
    CLS_MEM  = 3'd3,
    CLS_ALU  = 3'd4
  } op_cls_t;

endpackage

// File: rtl/mc_ctrl_fsm_if.sv
// mc_ctrl_fsm_if: bundle of the sequencer's handshake and status signals.
//   master modport (datapath / memory side): drives opcode, imem_ready,
//     dmem_ready, resume; observes state, retire, halted, fault, cycle_cnt,
//     instr_cnt.
//   slave modport (mc_ctrl_fsm): the mirror image.
// CNT_W must match the CNT_W of the attached mc_ctrl_fsm.
interface mc_ctrl_fsm_if #(
  parameter int CNT_W = 32
);
  import mc_ctrl_pkg::*;

  logic [5:0]         opcode;
  logic               imem_ready;
  logic               dmem_ready;
  logic               resume;
  logic [STATE_W-1:0] state;
  logic               retire;
  logic               halted;
  logic               fault;
  logic [CNT_W-1:0]   cycle_cnt;
  logic [CNT_W-1:0]   instr_cnt;

  modport master (
    output opcode, imem_ready, dmem_ready, resume,
    input  state, retire, halted, fault, cycle_cnt, instr_cnt
  );

  modport slave (
    input  opcode, imem_ready, dmem_ready, resume,
    output state, retire, halted, fault, cycle_cnt, instr_cnt
  );

endinterface

// File: rtl/mc_ctrl_fsm_op_class_decode.sv
// op_class_decode: purely combinational opcode-to-class map, shared between
// the sequencer's ID dispatch and the datapath control decoder.
//   opcode (in, 6) : instruction opcode
//   cls    (out)   : instruction class; unknown opcodes are ALU operations
module op_class_decode
  import mc_ctrl_pkg::*;
(
  input  logic [5:0] opcode,
  output op_cls_t    cls
);

  always_comb begin
    cls = CLS_ALU;
    case (opcode)
      OP_J, OP_JAL, OP_JR: cls = CLS_JUMP;
      OP_HALT:             cls = CLS_HALT;
      OP_BEQ:              cls = CLS_BR;
      OP_SW, OP_LW:        cls = CLS_MEM;
      default:             cls = CLS_ALU;
    endcase
  end

endmodule

// File: rtl/mc_ctrl_fsm.sv
// mc_ctrl_fsm: registered multi-cycle control sequencer.
//   CLK (in)  : clock, rising edge
//   RST (in)  : asynchronous active-high reset
//   bus (slave modport of mc_ctrl_fsm_if):
//     opcode/imem_ready/dmem_ready/resume in;
//     state, retire, halted, fault, cycle_cnt, instr_cnt out (all registered
//     or decoded from registered state only).
// Parameters: CNT_W counter width, TIMEOUT not-ready cycles in IF/MEM before
// FAULT (0 disables the timeout).
module mc_ctrl_fsm
  import mc_ctrl_pkg::*;
#(
  parameter int CNT_W   = 32,
  parameter int TIMEOUT = 15
) (
  input  logic          CLK,
  input  logic          RST,
  mc_ctrl_fsm_if.slave  bus
);

  // Keep the wait counter at least one bit wide when the timeout is disabled.
  localparam int WAIT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  state_t              state_q, state_d;
  logic [5:0]          op_q;
  logic [WAIT_W-1:0]   wait_q, wait_d;
  logic                retire_q, retire_d;
  logic [CNT_W-1:0]    cyc_q, ins_q;
  op_cls_t             cls;
  logic                ready_low;
  logic                timeout_hit;

  op_class_decode u_dec (
    .opcode (bus.opcode),
    .cls    (cls)
  );

  // Ready-low only matters in the two states that wait on memory.
  assign ready_low = ((state_q == S_IF)  && !bus.imem_ready) ||
                     ((state_q == S_MEM) && !bus.dmem_ready);

  assign timeout_hit = (TIMEOUT != 0) && ready_low &&
                       (wait_q == WAIT_W'(TIMEOUT));

  // State register and datapath-side registers
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q  <= S_IF;
      op_q     <= '0;
      wait_q   <= '0;
      retire_q <= 1'b0;
      cyc_q    <= '0;
      ins_q    <= '0;
    end else begin
      state_q  <= state_d;
      wait_q   <= wait_d;
      retire_q <= retire_d;
      if (state_q == S_ID)
        op_q <= bus.opcode;
      if ((state_q != S_HALT) && (state_q != S_FAULT))
        cyc_q <= cyc_q + CNT_W'(1);
      if (retire_q)
        ins_q <= ins_q + CNT_W'(1);
    end
  end

  // Next-state logic; retire_d marks transitions that complete an instruction
  always_comb begin
    state_d  = S_IF;
    retire_d = 1'b0;
    wait_d   = (ready_low && (TIMEOUT != 0)) ? wait_q + WAIT_W'(1) : '0;
    case (state_q)
      S_IF: begin
        if (bus.imem_ready)  state_d = S_ID;
        else if (timeout_hit) state_d = S_FAULT;
        else                 state_d = S_IF;
      end
      S_ID: begin
        case (cls)
          CLS_JUMP: begin state_d = S_IF;   retire_d = 1'b1; end
          CLS_HALT: begin state_d = S_HALT; retire_d = 1'b1; end
          CLS_BR:   state_d = S_EXE_BR;
          CLS_MEM:  state_d = S_EXE_MEM;
          default:  state_d = S_EXE_ALU;
        endcase
      end
      S_EXE_BR:  begin state_d = S_IF; retire_d = 1'b1; end
      S_EXE_ALU: state_d = S_WB_ALU;
      S_WB_ALU:  begin state_d = S_IF; retire_d = 1'b1; end
      S_EXE_MEM: state_d = S_MEM;
      S_MEM: begin
        // The opcode latched in ID decides the write-back path; the live
        // opcode input may already belong to the next instruction.
        if (bus.dmem_ready) begin
          if (op_q == OP_LW) begin
            state_d = S_WB_LD;
          end else begin
            state_d  = S_IF;
            retire_d = 1'b1;
          end
        end else if (timeout_hit) begin
          state_d = S_FAULT;
        end else begin
          state_d = S_MEM;
        end
      end
      S_WB_LD:   begin state_d = S_IF; retire_d = 1'b1; end
      S_HALT:    state_d = bus.resume ? S_IF : S_HALT;
      S_FAULT:   state_d = S_FAULT;
      default:   state_d = S_IF;
    endcase
  end

  // Output decode from registered state only
  always_comb begin
    bus.state     = state_q;
    bus.halted    = (state_q == S_HALT);
    bus.fault     = (state_q == S_FAULT);
    bus.retire    = retire_q;
    bus.cycle_cnt = cyc_q;
    bus.instr_cnt = ins_q;
  end

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Testbench for mc_ctrl_fsm: two instances (CNT_W = 32 and CNT_W = 4) share
// one directed stimulus stream. Each step names the state and retire value
// expected after the next rising edge; a small model tracks the counters.
module tb_mc_ctrl_fsm;
  import mc_ctrl_pkg::*;

  logic CLK = 1'b0;
  logic RST;
  int   checks = 0;
  int   errors = 0;

  state_t      exp_st;
  logic        exp_ret;
  logic [31:0] exp_cyc;
  logic [31:0] exp_ins;

  mc_ctrl_fsm_if #(.CNT_W(32)) bus  ();
  mc_ctrl_fsm_if #(.CNT_W(4))  bus4 ();

  mc_ctrl_fsm #(.CNT_W(32), .TIMEOUT(15)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus.slave)
  );

  mc_ctrl_fsm #(.CNT_W(4), .TIMEOUT(15)) dut4 (
    .CLK (CLK),
    .RST (RST),
    .bus (bus4.slave)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, "/state"},   32'(bus.state),     32'(exp_st));
    check({tag, "/retire"},  32'(bus.retire),    32'(exp_ret));
    check({tag, "/halted"},  32'(bus.halted),    32'(exp_st == S_HALT));
    check({tag, "/fault"},   32'(bus.fault),     32'(exp_st == S_FAULT));
    check({tag, "/cyc"},     bus.cycle_cnt,      exp_cyc);
    check({tag, "/ins"},     bus.instr_cnt,      exp_ins);
    check({tag, "/state4"},  32'(bus4.state),    32'(exp_st));
    check({tag, "/cyc4"},    32'(bus4.cycle_cnt), {28'd0, exp_cyc[3:0]});
    check({tag, "/ins4"},    32'(bus4.instr_cnt), {28'd0, exp_ins[3:0]});
  endtask

  task automatic drive(input logic [5:0] op, input logic ir, input logic dr, input logic rs);
    bus.opcode      = op;  bus4.opcode     = op;
    bus.imem_ready  = ir;  bus4.imem_ready = ir;
    bus.dmem_ready  = dr;  bus4.dmem_ready = dr;
    bus.resume      = rs;  bus4.resume     = rs;
  endtask

  // Advance one clock and check against the state/retire expected after it.
  task automatic step(input state_t nst, input logic nret, input string tag);
    if ((exp_st != S_HALT) && (exp_st != S_FAULT)) exp_cyc = exp_cyc + 32'd1;
    if (exp_ret) exp_ins = exp_ins + 32'd1;
    @(posedge CLK);
    #1;
    exp_st  = nst;
    exp_ret = nret;
    check_all(tag);
  endtask

  // Asserted between edges: outputs must clear before any clock edge.
  task automatic do_reset(input string tag);
    #2;
    RST = 1'b1;
    #1;
    exp_st = S_IF; exp_ret = 1'b0; exp_cyc = '0; exp_ins = '0;
    check_all({tag, "_async"});
    @(posedge CLK);
    #1;
    check_all({tag, "_held"});
    RST = 1'b0;
  endtask

  state_t     tr1 [18];
  logic [5:0] ops1 [5];

  initial begin
    tr1 = '{S_ID, S_EXE_ALU, S_WB_ALU, S_IF,
            S_ID, S_EXE_BR, S_IF,
            S_ID, S_EXE_MEM, S_MEM, S_WB_LD, S_IF,
            S_ID, S_EXE_MEM, S_MEM, S_IF,
            S_ID, S_IF};
    ops1 = '{6'b000000, OP_BEQ, OP_LW, OP_SW, OP_J};

    RST = 1'b1;
    drive(6'd0, 1'b0, 1'b0, 1'b0);
    exp_st = S_IF; exp_ret = 1'b0; exp_cyc = '0; exp_ins = '0;
    #2;
    check_all("por");
    @(posedge CLK);
    #1;
    RST = 1'b0;

    // add, beq, lw, sw, j with memories always ready
    begin
      int k = 0;
      drive(ops1[0], 1'b1, 1'b1, 1'b0);
      for (int i = 0; i < 18; i++) begin
        step(tr1[i], tr1[i] == S_IF, "trace1");
        if ((tr1[i] == S_IF) && (k < 4)) begin
          k++;
          drive(ops1[k], 1'b1, 1'b1, 1'b0);
        end
      end
    end
    // j retire is visible now; instr_cnt catches up one cycle later
    check("trace1_cycles", bus.cycle_cnt, 32'd18);
    check("trace1_instr_pre", bus.instr_cnt, 32'd4);
    drive(6'd0, 1'b0, 1'b1, 1'b0);
    step(S_IF, 1'b0, "if_stall");
    check("trace1_instr", bus.instr_cnt, 32'd5);
    check("trace1_cycles_next", bus.cycle_cnt, 32'd19);

    // lw with three not-ready MEM cycles; opcode changes while in MEM
    drive(OP_LW, 1'b1, 1'b0, 1'b0);
    step(S_ID,      1'b0, "lw_id");
    step(S_EXE_MEM, 1'b0, "lw_exe");
    step(S_MEM,     1'b0, "lw_mem1");
    step(S_MEM,     1'b0, "lw_mem2");
    step(S_MEM,     1'b0, "lw_mem3");
    step(S_MEM,     1'b0, "lw_mem4");
    drive(OP_HALT, 1'b1, 1'b1, 1'b0);
    step(S_WB_LD,   1'b0, "lw_wb");
    step(S_IF,      1'b1, "lw_retire");
    step(S_ID,      1'b0, "halt_id");

    // halt, ten frozen cycles, then resume
    step(S_HALT, 1'b1, "halt_enter");
    check("halt_cycles", bus.cycle_cnt, 32'd29);
    for (int i = 0; i < 10; i++) step(S_HALT, 1'b0, "halt_hold");
    check("halt_frozen", bus.cycle_cnt, 32'd29);
    drive(OP_J, 1'b1, 1'b1, 1'b1);
    step(S_IF, 1'b0, "resume");
    drive(OP_J, 1'b1, 1'b1, 1'b0);
    step(S_ID, 1'b0, "resume_count");
    check("resume_cycles", bus.cycle_cnt, 32'd30);
    step(S_IF, 1'b1, "resume_j");

    // imem_ready stuck low: FAULT after 16 not-ready IF cycles
    do_reset("rst_to1");
    drive(6'd0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 15; i++) step(S_IF, 1'b0, "to_wait");
    step(S_FAULT, 1'b0, "to_fault");
    drive(6'd0, 1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) step(S_FAULT, 1'b0, "fault_hold");
    check("fault_cycles", bus.cycle_cnt, 32'd16);

    // ready rises in the cycle where the counter hits TIMEOUT: ready wins
    do_reset("rst_to2");
    drive(6'd0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 15; i++) step(S_IF, 1'b0, "to2_wait");
    drive(OP_J, 1'b1, 1'b1, 1'b0);
    step(S_ID, 1'b0, "to2_id");
    step(S_IF, 1'b1, "to2_j");

    // reset mid-instruction while stalled in MEM
    drive(OP_SW, 1'b1, 1'b0, 1'b0);
    step(S_ID,      1'b0, "sw_id");
    step(S_EXE_MEM, 1'b0, "sw_exe");
    step(S_MEM,     1'b0, "sw_mem1");
    step(S_MEM,     1'b0, "sw_mem2");
    do_reset("rst_mem");

    // 17 jumps: the 4-bit instruction counter wraps to 1
    drive(OP_J, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 17; i++) begin
      step(S_ID, 1'b0, "wrap_id");
      step(S_IF, 1'b1, "wrap_if");
    end
    drive(6'd0, 1'b0, 1'b1, 1'b0);
    step(S_IF, 1'b0, "wrap_final");
    check("wrap_instr4", 32'(bus4.instr_cnt), 32'd1);
    check("wrap_instr32", bus.instr_cnt, 32'd17);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
